// File: rtl/uart_cmd_initiator.sv
// uart_cmd_initiator: turns host register read/write requests into byte
// frames for a UART tx FIFO and collects the two-byte read response from
// the matching rx FIFO, with a per-byte response timeout.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only while idle and out of
// reset, so at most one request is ever in flight. Completion is reported by
// a single-cycle rsp_valid_o pulse. rsp_rdata_o and rsp_timeout_o are held
// until the next completion.
module uart_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_timeout_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_write_buffer_o,
  input  logic        tx_buffer_full_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_read_buffer_o,
  input  logic        rx_buffer_data_present_i,
  output logic        busy_o
);

  // Counter sized to hold TIMEOUT_CYCLES; it stops at the limit, never wraps.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t        r_state;
  logic          r_write;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_tcnt;
  logic          r_rx_cnt;
  logic [7:0]    r_rdata_hi;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_rdata;
  logic          r_rsp_timeout;

  logic [7:0]    w_tx_byte;
  logic          w_last_byte;
  logic          w_tx_fire;
  logic          w_rx_pop;
  logic          w_accept;

  // Frame byte selected by the current index: opcode, address, then write data.
  always_comb begin
    w_tx_byte = 8'h00;
    case (r_idx)
      3'd0:    w_tx_byte = r_write ? 8'h02 : 8'h01;
      3'd1:    w_tx_byte = r_addr[15:8];
      3'd2:    w_tx_byte = r_addr[7:0];
      3'd3:    w_tx_byte = r_wdata[15:8];
      3'd4:    w_tx_byte = r_wdata[7:0];
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Strobes are gated by rst so a reset aborts the frame in the same cycle.
  assign w_last_byte       = r_write ? (r_idx == 3'd4) : (r_idx == 3'd2);
  assign w_tx_fire         = ~rst & (r_state == SEND) & ~tx_buffer_full_i;
  assign w_rx_pop          = ~rst & rx_buffer_data_present_i &
                             ((r_state == IDLE) | (r_state == WAIT_RSP));
  assign req_ready_o       = ~rst & (r_state == IDLE);
  assign w_accept          = req_valid_i & req_ready_o;
  assign busy_o            = ~rst & (r_state != IDLE);
  assign tx_write_buffer_o = w_tx_fire;
  assign tx_data_o         = (~rst & (r_state == SEND)) ? w_tx_byte : 8'h00;
  assign rx_read_buffer_o  = w_rx_pop;
  assign rsp_valid_o       = r_rsp_valid;
  assign rsp_rdata_o       = r_rsp_rdata;
  assign rsp_timeout_o     = r_rsp_timeout;

  // Request sequencer: send the frame, gather the response, report completion.
  // Bytes popped while idle are stale and are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_write       <= 1'b0;
      r_addr        <= 16'h0000;
      r_wdata       <= 16'h0000;
      r_idx         <= 3'd0;
      r_tcnt        <= '0;
      r_rx_cnt      <= 1'b0;
      r_rdata_hi    <= 8'h00;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 16'h0000;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write <= req_write_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_idx   <= 3'd0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_tx_fire) begin
            if (w_last_byte) begin
              if (r_write) begin
                r_state       <= DONE;
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= 16'h0000;
                r_rsp_timeout <= 1'b0;
              end else begin
                r_state  <= WAIT_RSP;
                r_tcnt   <= '0;
                r_rx_cnt <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        WAIT_RSP: begin
          if (w_rx_pop) begin
            r_tcnt <= '0;
            if (!r_rx_cnt) begin
              r_rdata_hi <= rx_data_i;
              r_rx_cnt   <= 1'b1;
            end else begin
              r_state       <= DONE;
              r_rsp_valid   <= 1'b1;
              r_rsp_rdata   <= {r_rdata_hi, rx_data_i};
              r_rsp_timeout <= 1'b0;
            end
          end else if (r_tcnt == TLAST) begin
            r_state       <= DONE;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= 16'h0000;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Bench for uart_cmd_initiator: models the tx/rx FIFOs around the DUT,
// predicts frames and completion timing from the protocol rules, and checks.
module tb_uart_cmd_initiator;

  localparam int T = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [15:0] req_addr_i;
  logic [15:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        rsp_timeout_o;
  logic [7:0]  tx_data_o;
  logic        tx_write_buffer_o;
  logic        tx_buffer_full_i;
  logic [7:0]  rx_data_i;
  logic        rx_read_buffer_o;
  logic        rx_buffer_data_present_i;
  logic        busy_o;

  always #5 clk = ~clk;

  uart_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid_i              (req_valid_i),
    .req_ready_o              (req_ready_o),
    .req_write_i              (req_write_i),
    .req_addr_i               (req_addr_i),
    .req_wdata_i              (req_wdata_i),
    .rsp_valid_o              (rsp_valid_o),
    .rsp_rdata_o              (rsp_rdata_o),
    .rsp_timeout_o            (rsp_timeout_o),
    .tx_data_o                (tx_data_o),
    .tx_write_buffer_o        (tx_write_buffer_o),
    .tx_buffer_full_i         (tx_buffer_full_i),
    .rx_data_i                (rx_data_i),
    .rx_read_buffer_o         (rx_read_buffer_o),
    .rx_buffer_data_present_i (rx_buffer_data_present_i),
    .busy_o                   (busy_o)
  );

  // ---------------- environment state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  rx_q[$];
  int          rx_at_cyc[$];
  logic [7:0]  rx_at_byte[$];
  logic [7:0]  tx_got[$];
  int          tx_first;
  int          tx_last;
  int          full_left = 0;
  int          full_at   = 0;
  int          full_len  = 0;
  bit          full_armed = 0;
  int          rsp_cnt = 0;
  logic [15:0] rsp_data;
  logic        rsp_to;
  int          rsp_cyc;
  int          pops = 0;
  int          viol_full = 0;
  int          viol_empty = 0;
  int          viol_ready = 0;
  bit          accepted;
  int          acc_cyc;
  logic [15:0] last_rdata = 16'h0000;
  bit          rd_arm = 0;
  int          rd_n;
  int          rd_gap0;
  int          rd_gap1;
  logic [7:0]  rd_b1;
  logic [7:0]  rd_b2;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present this cycle's FIFO-side inputs and let combinational outputs settle.
  task automatic tick_pre();
    while (rx_at_cyc.size() > 0 && rx_at_cyc[0] <= cyc) begin
      rx_q.push_back(rx_at_byte.pop_front());
      void'(rx_at_cyc.pop_front());
    end
    tx_buffer_full_i         = (full_left > 0);
    rx_buffer_data_present_i = (rx_q.size() > 0);
    rx_data_i                = (rx_q.size() > 0) ? rx_q[0] : 8'($urandom);
    #1;
  endtask

  // Record what the DUT did this cycle, update FIFO models, advance a clock.
  task automatic tick_post();
    if (full_left > 0) full_left--;
    if (tx_write_buffer_o) begin
      if (tx_buffer_full_i) viol_full++;
      if (tx_got.size() == 0) tx_first = cyc;
      tx_got.push_back(tx_data_o);
      tx_last = cyc;
      if (full_armed && tx_got.size() == full_at) begin
        full_left  = full_len;
        full_armed = 0;
      end
      if (rd_arm && tx_got.size() == rd_n) begin
        // Response bytes arrive relative to the first waiting cycle.
        if (rd_gap0 < T) begin
          rx_at_cyc.push_back(cyc + 1 + rd_gap0);
          rx_at_byte.push_back(rd_b1);
          if (rd_gap1 < T) begin
            rx_at_cyc.push_back(cyc + 1 + rd_gap0 + 1 + rd_gap1);
            rx_at_byte.push_back(rd_b2);
          end
        end
        rd_arm = 0;
      end
    end
    if (rx_read_buffer_o) begin
      if (rx_q.size() == 0) viol_empty++;
      else void'(rx_q.pop_front());
      pops++;
    end
    if (req_ready_o && busy_o) viol_ready++;
    if (req_valid_i && req_ready_o) begin
      accepted = 1;
      acc_cyc  = cyc;
    end
    if (rsp_valid_o) begin
      rsp_cnt++;
      rsp_data = rsp_rdata_o;
      rsp_to   = rsp_timeout_o;
      rsp_cyc  = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 16'h0000);
    chk({tag, "_rsp_timeout"}, rsp_timeout_o, 1'b0);
    chk({tag, "_tx_write"}, tx_write_buffer_o, 1'b0);
    chk({tag, "_tx_data"}, tx_data_o, 8'h00);
    chk({tag, "_rx_read"}, rx_read_buffer_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
  endtask

  // One complete request with reference-model prediction of frame, timing and result.
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int g0, input int g1, input logic [7:0] b1, input logic [7:0] b2,
                        input int f_at, input int f_len, input string tag);
    logic [7:0]  exp_q[$];
    int          n;
    int          start;
    int          stall;
    int          l_exp;
    int          e_cyc;
    int          exp_rsp_cyc;
    logic [15:0] exp_data;
    logic        exp_to;
    int          exp_pops;
    int          pops0;
    int          base_rsp;
    int          wait_n;

    exp_q.push_back(wr ? 8'h02 : 8'h01);
    exp_q.push_back(addr[15:8]);
    exp_q.push_back(addr[7:0]);
    if (wr) begin
      exp_q.push_back(wdata[15:8]);
      exp_q.push_back(wdata[7:0]);
    end
    n = exp_q.size();

    tx_got.delete();
    full_at    = f_at;
    full_len   = f_len;
    full_armed = (f_len > 0 && f_at >= 1 && f_at < n);
    stall      = full_armed ? f_len : 0;
    rd_arm     = !wr;
    rd_n       = n;
    rd_gap0    = g0;
    rd_gap1    = g1;
    rd_b1      = b1;
    rd_b2      = b2;
    viol_full  = 0;
    viol_empty = 0;
    viol_ready = 0;

    if (wr) begin
      exp_data = 16'h0000; exp_to = 1'b0; exp_pops = 0;
    end else if (g0 >= T) begin
      exp_data = 16'h0000; exp_to = 1'b1; exp_pops = 0;
    end else if (g1 >= T) begin
      exp_data = 16'h0000; exp_to = 1'b1; exp_pops = 1;
    end else begin
      exp_data = {b1, b2}; exp_to = 1'b0; exp_pops = 2;
    end

    pops0    = pops;
    base_rsp = rsp_cnt;
    start    = cyc;
    accepted = 0;
    acc_cyc  = -1;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    tick_pre();
    chk({tag, "_idle_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_held_rdata"}, rsp_rdata_o, last_rdata);
    tick_post();
    wait_n = 1;
    while (!accepted && wait_n < 20) begin
      tick();
      wait_n++;
    end
    req_valid_i = 1'b0;
    req_addr_i  = 16'($urandom);
    req_wdata_i = 16'($urandom);
    chk({tag, "_accepted"}, accepted, 1'b1);
    chk({tag, "_accept_cycle"}, acc_cyc, start);

    l_exp = start + n + stall;
    e_cyc = l_exp + 1;
    if (wr)            exp_rsp_cyc = l_exp + 1;
    else if (g0 >= T)  exp_rsp_cyc = e_cyc + T;
    else if (g1 >= T)  exp_rsp_cyc = e_cyc + g0 + 1 + T;
    else               exp_rsp_cyc = e_cyc + g0 + g1 + 2;

    wait_n = 0;
    while (rsp_cnt == base_rsp && wait_n < 300) begin
      tick();
      wait_n++;
    end
    chk({tag, "_rsp_seen"}, rsp_cnt - base_rsp, 1);
    chk({tag, "_rsp_cycle"}, rsp_cyc, exp_rsp_cyc);
    chk({tag, "_rsp_rdata"}, rsp_data, exp_data);
    chk({tag, "_rsp_timeout"}, rsp_to, exp_to);
    chk({tag, "_tx_count"}, tx_got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_tx_byte%0d", tag, i), (i < tx_got.size()) ? {24'h0, tx_got[i]} : 32'hDEAD_BEEF, exp_q[i]);
    chk({tag, "_tx_first_cycle"}, tx_first, start + 1);
    chk({tag, "_tx_last_cycle"}, tx_last, l_exp);
    chk({tag, "_rx_pops"}, pops - pops0, exp_pops);
    chk({tag, "_strobe_while_full"}, viol_full, 0);
    chk({tag, "_pop_while_empty"}, viol_empty, 0);
    chk({tag, "_ready_while_busy"}, viol_ready, 0);
    last_rdata = exp_data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          base;
    int          wait_n;
    bit          wr;
    int          n;
    int          g0;
    int          g1;
    int          f_len;
    int          f_at;

    rst = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = 16'h0000;
    req_wdata_i = 16'h0000;
    tx_buffer_full_i = 1'b0;
    rx_data_i = 8'h00;
    rx_buffer_data_present_i = 1'b0;
    #2;

    // Reset with a byte waiting in rx: it must not be popped while in reset.
    rx_q.push_back(8'h3C);
    repeat (3) tick();
    tick_pre();
    reset_checks("por");
    tick_post();
    rst = 1'b0;

    // First cycle out of reset: ready, and the waiting byte is flushed.
    tick_pre();
    chk("por_ready_after", req_ready_o, 1'b1);
    chk("por_flush_pop", rx_read_buffer_o, 1'b1);
    tick_post();
    chk("por_flush_empty", rx_q.size(), 0);

    do_req(1'b1, 16'h1234, 16'hABCD, 0, 0, 8'h00, 8'h00, 0, 0, "wr_basic");
    do_req(1'b0, 16'h0010, 16'h0000, 2, 1, 8'h5A, 8'hA5, 0, 0, "rd_basic");
    do_req(1'b0, 16'h4321, 16'h0000, T, 0, 8'h11, 8'h22, 0, 0, "rd_timeout");
    do_req(1'b0, 16'h00FF, 16'h0000, T - 1, T - 1, 8'hC3, 8'h3C, 0, 0, "rd_edge");
    do_req(1'b0, 16'h8001, 16'h0000, 3, T, 8'h99, 8'h66, 0, 0, "rd_part_to");
    do_req(1'b1, 16'hCAFE, 16'h5555, 0, 0, 8'h00, 8'h00, 2, 10, "wr_full");

    // Stale byte while idle is discarded; the following read is unaffected.
    rx_q.push_back(8'h77);
    tick_pre();
    chk("stale_pop", rx_read_buffer_o, 1'b1);
    tick_post();
    chk("stale_empty", rx_q.size(), 0);
    do_req(1'b0, 16'h2002, 16'h0000, 0, 0, 8'h01, 8'h02, 0, 0, "rd_after_stale");

    // Reset in the middle of a write frame.
    tx_got.delete();
    full_armed = 0;
    rd_arm = 0;
    accepted = 0;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 16'hBEEF;
    req_wdata_i = 16'h1357;
    wait_n = 0;
    while (!accepted && wait_n < 20) begin tick(); wait_n++; end
    req_valid_i = 1'b0;
    wait_n = 0;
    while (tx_got.size() < 2 && wait_n < 20) begin tick(); wait_n++; end
    chk("abort_two_bytes", tx_got.size(), 2);
    base = rsp_cnt;
    rst = 1'b1;
    tick_pre();
    chk("abort_tx_now", tx_write_buffer_o, 1'b0);
    chk("abort_data_now", tx_data_o, 8'h00);
    tick_post();
    tick_pre();
    reset_checks("abort");
    tick_post();
    rst = 1'b0;
    repeat (6) tick();
    chk("abort_no_more_tx", tx_got.size(), 2);
    chk("abort_no_rsp", rsp_cnt, base);
    last_rdata = 16'h0000;
    do_req(1'b1, 16'h0A0B, 16'h0C0D, 0, 0, 8'h00, 8'h00, 0, 0, "wr_after_abort");

    // Randomised back-to-back traffic.
    for (int k = 0; k < 24; k++) begin
      wr    = 1'($urandom_range(0, 1));
      n     = wr ? 5 : 3;
      g0    = ($urandom_range(0, 4) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, T - 1);
      g1    = ($urandom_range(0, 4) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, T - 1);
      f_len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      f_at  = $urandom_range(1, n - 1);
      do_req(wr, 16'($urandom), 16'($urandom), g0, g1, 8'($urandom), 8'($urandom),
             f_at, f_len, $sformatf("rnd%0d", k));
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_initiator.md
UART_CMD_INITIATOR -- requirements
Module: uart_cmd_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535: clk cycles allowed between read-response bytes.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  1  host request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when req_valid_i & req_ready_o.
REQ-006 SHALL have port req_write_i  input  1  1=write, 0=read.
REQ-007 SHALL have port req_addr_i  input  16  target bus address.
REQ-008 SHALL have port req_wdata_i  input  16  write data.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata_o  output  16  read data; held until next completion.
REQ-011 SHALL have port rsp_timeout_o  output  1  completion was a timeout; valid with rsp_valid_o.
REQ-012 SHALL have port tx_data_o  output  8  byte to UART tx FIFO.
REQ-013 SHALL have port tx_write_buffer_o  output  1  tx FIFO write strobe.
REQ-014 SHALL have port tx_buffer_full_i  input  1  tx FIFO full.
REQ-015 SHALL have port rx_data_i  input  8  head byte of rx FIFO (first-word-fall-through).
REQ-016 SHALL have port rx_read_buffer_o  output  1  rx FIFO pop strobe.
REQ-017 SHALL have port rx_buffer_data_present_i  input  1  rx FIFO non-empty.
REQ-018 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, WAIT_RSP, DONE.
REQ-020 SHALL assert req_ready_o only in IDLE; on acceptance latch write flag, addr, wdata; go to SEND with byte index 0.
REQ-021 Write frame SHALL be 5 bytes in order: 0x02, addr[15:8], addr[7:0], wdata[15:8], wdata[7:0].
REQ-022 Read frame SHALL be 3 bytes in order: 0x01, addr[15:8], addr[7:0].
REQ-023 In SEND, SHALL assert tx_write_buffer_o for exactly one cycle per byte, only when tx_buffer_full_i=0, and advance the index that cycle; stall with strobe low while full.
REQ-024 After the last write-frame byte, SHALL go to DONE; no response bytes are expected for writes.
REQ-025 After the last read-frame byte, SHALL go to WAIT_RSP with timeout counter and received-byte count cleared.
REQ-026 In WAIT_RSP, when rx_buffer_data_present_i=1, SHALL pulse rx_read_buffer_o for one cycle and capture rx_data_i the same cycle: first byte -> rdata[15:8], second -> rdata[7:0]; at most one pop per cycle.
REQ-027 Timeout counter SHALL increment every WAIT_RSP cycle without a pop, clear on each pop, and on reaching TIMEOUT_CYCLES SHALL go to DONE with timeout flag set and rdata forced to 0x0000.
REQ-028 After the second captured byte, SHALL go to DONE with timeout flag clear.
REQ-029 DONE SHALL last one cycle: rsp_valid_o=1, rsp_rdata_o and rsp_timeout_o valid; then IDLE.
REQ-030 For writes, rsp_rdata_o SHALL be 0x0000 and rsp_timeout_o 0.
REQ-031 In IDLE, any rx byte present SHALL be popped and discarded (stale-data flush); same-cycle request acceptance is still allowed.
REQ-032 Earliest req_ready_o after acceptance SHALL be the cycle after DONE; back-to-back requests need no extra idle cycle.
REQ-033 Timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL not wrap.

Reset
REQ-034 While rst=1, SHALL enter IDLE; req_ready_o=0 during reset, 1 the cycle after; rsp_valid_o=0, rsp_rdata_o=0x0000, rsp_timeout_o=0, tx_write_buffer_o=0, tx_data_o=0x00, rx_read_buffer_o=0, busy_o=0.
REQ-035 rst asserted mid-frame SHALL abort immediately; no further tx/rx strobes and no rsp_valid_o for the aborted request.

Verification
REQ-036 Write addr=0x1234 data=0xABCD, tx never full -> tx bytes 02,12,34,AB,CD on 5 consecutive cycles, then rsp_valid_o with timeout=0.
REQ-037 Read addr=0x0010, rx supplies 0x5A then 0xA5 -> tx 01,00,10; two rx pops; rsp_rdata_o=0x5AA5, timeout=0.
REQ-038 Read with TIMEOUT_CYCLES=16, no rx data -> rsp_valid_o exactly 16 cycles after WAIT_RSP entry, timeout=1, rdata=0x0000.
REQ-039 tx_buffer_full_i held high 10 cycles during byte 2 of write -> no strobe while full; byte order and count unchanged.
REQ-040 Stale rx byte 0x77 present in IDLE, then read returning 0x0102 -> 0x77 discarded, rsp_rdata_o=0x0102.
REQ-041 rst pulsed after 2nd byte of a write -> outputs at reset values, no rsp_valid_o; next request completes normally.
